// File: rtl/up_down_counter_pkg.sv
// up_down_counter_pkg: shared width default and count direction encodings
package up_down_counter_pkg;
  localparam int N_DEFAULT = 10;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/up_down_counter_if.sv
// up_down_counter_if: load/count control bundle with registered count and terminal-count flag
interface up_down_counter_if #(parameter int N = 10);
  logic load;
  logic [N-1:0] in;
  logic en;
  logic din;
  logic [N-1:0] out;
  logic cout;
  modport master (output load, in, en, din, input out, cout);
  modport slave (input load, in, en, din, output out, cout);
endinterface

// File: rtl/up_down_counter.sv
// up_down_counter: N-bit loadable up/down counter with combinational wrap indicator
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input logic clk,
  input logic rst,
  up_down_counter_if.slave bus
);
  logic [N-1:0] nxt;
  // next count: load wins over stepping; disabled count holds
  always_comb begin
    nxt = bus.load ? bus.in : !bus.en ? bus.out : bus.din == DIR_DOWN ? bus.out - N'(1) : bus.out + N'(1);
    bus.cout = !rst && !bus.load && bus.en && (bus.din == DIR_DOWN ? bus.out == '0 : &bus.out);
  end
  // count register with synchronous reset taking priority
  always_ff @(posedge clk) bus.out <= rst ? '0 : nxt;
endmodule

// File: tb/tb_up_down_counter.sv
// tb_up_down_counter: directed vectors with hand-computed expectations
module tb_up_down_counter;
  localparam int N = 10;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int failures = 0;
  up_down_counter_if #(.N(N)) bus ();
  up_down_counter #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1;
    bus.load = 0;
    bus.in = '0;
    bus.en = 1;
    bus.din = 1;
    step();
    check("rst_out", 32'(bus.out), 0);
    check("rst_cout", 32'(bus.cout), 0);
    rst = 0;
    bus.load = 1;
    bus.in = 10'd123;
    step();
    check("load_123", 32'(bus.out), 123);
    bus.load = 0;
    bus.din = 0;
    for (int i = 0; i < 5; i++) begin
      #1 check("up_cout", 32'(bus.cout), 0);
      step();
      check("up_out", 32'(bus.out), 32'(124 + i));
    end
    bus.din = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("down_out", 32'(bus.out), 32'(127 - i));
    end
    bus.load = 1;
    bus.in = 10'd1023;
    bus.din = 0;
    step();
    check("load_max", 32'(bus.out), 1023);
    bus.load = 0;
    #1 check("upwrap_cout_pre", 32'(bus.cout), 1);
    step();
    check("upwrap_out", 32'(bus.out), 0);
    check("upwrap_cout_post", 32'(bus.cout), 0);
    bus.load = 1;
    bus.in = 10'd0;
    step();
    bus.load = 0;
    bus.din = 1;
    #1 check("dnwrap_cout_pre", 32'(bus.cout), 1);
    step();
    check("dnwrap_out", 32'(bus.out), 1023);
    bus.en = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_out", 32'(bus.out), 1023);
      check("hold_cout", 32'(bus.cout), 0);
    end
    bus.en = 1;
    bus.din = 0;
    #1 check("prio_cout_pre", 32'(bus.cout), 1);
    bus.load = 1;
    bus.in = 10'd5;
    #1 check("prio_cout_load", 32'(bus.cout), 0);
    step();
    check("prio_out", 32'(bus.out), 5);
    bus.load = 0;
    step();
    check("count_6", 32'(bus.out), 6);
    rst = 1;
    bus.load = 1;
    bus.in = 10'd77;
    #1 check("midrst_cout", 32'(bus.cout), 0);
    step();
    check("midrst_out", 32'(bus.out), 0);
    rst = 0;
    bus.load = 0;
    step();
    check("resume_out", 32'(bus.out), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/up_down_counter.md
UP_DOWN_COUNTER -- requirements
Module: UpDown_Counter

Interface
REQ-001 Parameter N, default 10, SHALL set the counter width in bits (N >= 2).
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Load  input  1  SHALL be the synchronous parallel-load request.
REQ-005 In  input  N  SHALL be the parallel-load value.
REQ-006 En  input  1  SHALL be the count enable.
REQ-007 Din  input  1  SHALL be the count direction: 0 counts up, 1 counts down.
REQ-008 Out  output  N  SHALL be the registered count value.
REQ-009 Cout  output  1  SHALL be the combinational carry/borrow (terminal-count) indicator.

Function
REQ-010 Each rising clk edge SHALL apply the first matching rule, in priority order: rst, Load, En.
REQ-011 When rst=1, Out SHALL become 0.
REQ-012 When rst=0 and Load=1, Out SHALL become In, regardless of En and Din.
REQ-013 When rst=0, Load=0, En=1 and Din=0, Out SHALL become Out+1 modulo 2^N; 2^N-1 wraps to 0.
REQ-014 When rst=0, Load=0, En=1 and Din=1, Out SHALL become Out-1 modulo 2^N; 0 wraps to 2^N-1.
REQ-015 When rst=0, Load=0 and En=0, Out SHALL hold its value.
REQ-016 Cout SHALL be 1 only when all of the following hold: rst=0, Load=0, En=1, and either (Din=0 and Out=2^N-1) or (Din=1 and Out=0).
REQ-017 Cout SHALL be 0 in every other case, so it flags the wrap that the next edge will perform.
REQ-018 Cout SHALL respond combinationally to changes on Din, En, Load and rst, with no added latency.
REQ-019 A change of Din between edges SHALL take effect on the next edge, with no dead cycle and no extra step.
REQ-020 Load and wrap on the same edge: Load SHALL win, Out SHALL become In, and Cout SHALL be 0.
REQ-021 Count latency SHALL be one clk cycle: Out reflects a load or a step immediately after the edge that performs it.
REQ-022 Inputs SHALL be sampled only at the rising clk edge; there SHALL be no asynchronous paths into Out.

Reset
REQ-023 Reset SHALL be synchronous and active-high, and SHALL take priority over Load and En.
REQ-024 After reset, Out SHALL be 0, and Cout SHALL be 0 while rst=1.
REQ-025 Asserting rst mid-count SHALL clear Out on the next edge; counting SHALL resume from 0 on the first edge after rst deasserts.
REQ-026 Before the first reset, Out is unspecified; the bench SHALL apply reset first.

Structure
REQ-027 A shared package SHALL hold the default width constant (10) and the direction encodings DIR_UP=0 and DIR_DOWN=1.
REQ-028 The block SHALL be a single module with one N-bit register and a combinational next-state/Cout block; no sub-module is required.

Verification
REQ-029 Reset then load: rst=1 for 1 cycle, then Load=1 with In=123 for 1 edge, then Load=0, En=1, Din=0 for 5 edges -> Out=123, then 124..128, with Cout=0 throughout.
REQ-030 Direction switch: from Out=128, set Din=1 for 3 edges -> Out=127, 126, 125; the change takes effect on the first edge.
REQ-031 Up wrap: load 1023 with En=1, Din=0 -> Cout=1 before the edge; next edge gives Out=0 and Cout=0.
REQ-032 Down wrap: load 0 with En=1, Din=1 -> Cout=1 before the edge; next edge gives Out=1023.
REQ-033 Hold and priority: En=0 for 4 edges -> Out unchanged and Cout=0; at Out=1023 with Din=0, Load=1 and In=5 -> Out=5 and Cout=0.
REQ-034 Reset mid-count: rst=1 together with Load=1 while counting -> Out=0 on the next edge; after rst=0, counting up gives Out=1.
